vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator. Derives a pixel-rate tick from the system clock with an integer divider. Produces registered, mutually aligned pixel coordinates, sync pulses, a video-active flag, line/frame start strobes and a free-running frame counter. Sits between the board clock and the graphics pipeline (pixel renderer, frame-paced game logic), and supports any mode expressible as visible/porch/sync counts plus sync polarity.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT_PORCH, 16, pixels
- H_SYNC_PULSE, 96, pixels
- H_BACK_PORCH, 48, pixels
- V_VISIBLE, 480, active lines per frame
- V_FRONT_PORCH, 10, lines
- V_SYNC_PULSE, 2, lines
- V_BACK_PORCH, 33, lines
- HSYNC_POL, 0, active level of o_hsync (0 = active-low)
- VSYNC_POL, 0, active level of o_vsync
- CLK_DIV, 4, i_clk cycles per pixel, integer >= 1
- COUNT_W, 10, coordinate width
  - Requires H_TOTAL <= 2**COUNT_W and V_TOTAL <= 2**COUNT_W.
  - H_TOTAL = sum of H_* parameters; V_TOTAL = sum of V_* parameters.
- FRAME_W, 8, frame counter width
- i_clk  in  1  system clock
- i_resetn  in  1  reset, asynchronous, active-low
- i_enable  in  1  run; low stalls the generator
- o_pix_tick  out  1  one-i_clk strobe marking a pixel advance
- o_hcount  out  COUNT_W  current pixel column
- o_vcount  out  COUNT_W  current line
- o_hsync  out  1  horizontal sync, polarity HSYNC_POL
- o_vsync  out  1  vertical sync, polarity VSYNC_POL
- o_video_on  out  1  high when o_hcount < H_VISIBLE and o_vcount < V_VISIBLE
- o_line_start  out  1  high while o_hcount == 0
- o_frame_start  out  1  high while o_hcount == 0 and o_vcount == 0
- o_frame_count  out  FRAME_W  completed-frame count, wraps

## Operation
- Divider
  - r_div counts 0..CLK_DIV-1 and advances only while i_enable = 1.
  - o_pix_tick = i_enable and (r_div == CLK_DIV-1), combinational from registered state.
  - With CLK_DIV = 1, o_pix_tick = i_enable.
- Raster counters: on an i_clk edge with o_pix_tick = 1, o_hcount increments.
  - At H_TOTAL-1, o_hcount wraps to 0 and o_vcount increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0 and o_frame_count increments modulo 2**FRAME_W.
- Decode: every output is a register.
  - Sync, video and strobe outputs are decoded from the next coordinates, so at all times they describe the current (o_hcount, o_vcount).
  - No output ever lags the coordinates.
- Sync windows
  - o_hsync is active (= HSYNC_POL) iff H_VISIBLE+H_FRONT_PORCH <= o_hcount < H_VISIBLE+H_FRONT_PORCH+H_SYNC_PULSE.
  - o_vsync is defined the same way on o_vcount with the V_* parameters.
  - Outside the window each sync is at the inactive level.
- Stall: while i_enable = 0, r_div and all outputs hold; o_pix_tick = 0. Re-enable resumes from the held r_div.
- Reset: asynchronous, and may be asserted at any point in a line or frame. Reset values:
  - r_div = 0
  - o_hcount = H_TOTAL-1, o_vcount = V_TOTAL-1 (last blanking pixel)
  - o_hsync, o_vsync inactive
  - o_video_on = 0, o_line_start = 0, o_frame_start = 0
  - o_frame_count = 0
- First tick after reset moves to (0,0): o_frame_start = 1, o_frame_count = 1.

## Timing
- Pixel period: CLK_DIV i_clk cycles. Line: H_TOTAL pixels. Frame: H_TOTAL*V_TOTAL pixels.
- First o_pix_tick after reset release with i_enable = 1: CLK_DIV i_clk edges after release. At CLK_DIV = 1, this is the first edge.
- Latency: o_pix_tick to updated outputs is 1 i_clk edge. All outputs change on the same edge.
- o_line_start and o_frame_start each stay high for one full pixel period (CLK_DIV cycles), not a single i_clk.
- Defaults: 800 x 525 pixels per frame, 25 MHz pixel rate from 100 MHz.
  - hsync active for hcount 656..751.
  - vsync active for vcount 490..491.

## Test plan
- Reset: hold i_resetn = 0 mid-frame, check every output equals its reset value. Release with i_enable = 1 and check the first tick lands on (0,0) with o_frame_start = 1 and o_frame_count = 1.
- Defaults:
  - check o_hsync low exactly for hcount 656..751.
  - check the line wraps from 799 to 0.
  - check o_video_on high exactly for hcount 0..639 and vcount 0..479.
  - check o_vsync low exactly for vcount 490..491.
- Frame length: defaults give exactly 1,680,000 i_clk cycles between consecutive o_frame_start rising edges. CLK_DIV = 1 gives 420,000.
- Stall: drop i_enable for 37 cycles at hcount = 639. Check outputs and r_div hold, no o_pix_tick fires, and the line still totals 800 ticks.
- Polarity/mode: HSYNC_POL = VSYNC_POL = 1 with 800x600 timing (40/128/88 and 1/4/23, COUNT_W = 11). Check active-high syncs, hsync at 840..967, vsync at 601..604, frame of 1056 x 628.
- Frame counter wrap: FRAME_W = 2. Check the count sequence 1, 2, 3, 0, 1 across five frames.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA raster timing generator. An integer divider
//            derives a pixel tick from i_clk. Coordinates, syncs, video flag,
//            line/frame strobes and a frame counter are all registered and
//            updated together on each pixel tick.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
   parameter int   H_VISIBLE     = 640,
   parameter int   H_FRONT_PORCH = 16,
   parameter int   H_SYNC_PULSE  = 96,
   parameter int   H_BACK_PORCH  = 48,
   parameter int   V_VISIBLE     = 480,
   parameter int   V_FRONT_PORCH = 10,
   parameter int   V_SYNC_PULSE  = 2,
   parameter int   V_BACK_PORCH  = 33,
   parameter logic HSYNC_POL     = 1'b0,
   parameter logic VSYNC_POL     = 1'b0,
   parameter int   CLK_DIV       = 4,
   parameter int   COUNT_W       = 10,
   parameter int   FRAME_W       = 8
) (
   input  logic               i_clk,
   input  logic               i_resetn,
   input  logic               i_enable,
   output logic               o_pix_tick,
   output logic [COUNT_W-1:0] o_hcount,
   output logic [COUNT_W-1:0] o_vcount,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_video_on,
   output logic               o_line_start,
   output logic               o_frame_start,
   output logic [FRAME_W-1:0] o_frame_count
);

   localparam int c_H_TOTAL = H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
   localparam int c_V_TOTAL = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

   // Last coordinate of each axis (fits COUNT_W because totals <= 2**COUNT_W)
   localparam logic [COUNT_W-1:0] c_H_LAST = COUNT_W'(c_H_TOTAL - 1);
   localparam logic [COUNT_W-1:0] c_V_LAST = COUNT_W'(c_V_TOTAL - 1);

   // Window bounds carry one extra bit so an end bound equal to 2**COUNT_W still fits
   localparam logic [COUNT_W:0] c_H_VIS      = (COUNT_W+1)'(H_VISIBLE);
   localparam logic [COUNT_W:0] c_HS_START   = (COUNT_W+1)'(H_VISIBLE + H_FRONT_PORCH);
   localparam logic [COUNT_W:0] c_HS_END     = (COUNT_W+1)'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE);
   localparam logic [COUNT_W:0] c_V_VIS      = (COUNT_W+1)'(V_VISIBLE);
   localparam logic [COUNT_W:0] c_VS_START   = (COUNT_W+1)'(V_VISIBLE + V_FRONT_PORCH);
   localparam logic [COUNT_W:0] c_VS_END     = (COUNT_W+1)'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE);

   logic               w_pix_tick;
   logic               w_last_h;
   logic               w_last_v;
   logic [COUNT_W-1:0] w_next_h;
   logic [COUNT_W-1:0] w_next_v;
   logic [COUNT_W:0]   w_next_h_x;
   logic [COUNT_W:0]   w_next_v_x;
   logic               w_hs_act;
   logic               w_vs_act;

   generate
      if (CLK_DIV > 1) begin : g_div
         localparam int c_DIV_W = $clog2(CLK_DIV);
         localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

         logic [c_DIV_W-1:0] r_div;

         // Pixel-rate divider; freezes while the generator is stalled
         always_ff @(posedge i_clk or negedge i_resetn) begin
            if (!i_resetn) begin
               r_div <= '0;
            end else if (i_enable) begin
               r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
            end
         end

         assign w_pix_tick = i_enable && (r_div == c_DIV_LAST);
      end else begin : g_nodiv
         // Divide-by-one: every enabled clock is a pixel
         assign w_pix_tick = i_enable;
      end
   endgenerate

   assign o_pix_tick = w_pix_tick;

   // Next raster position; outputs are decoded from it so they never lag
   always_comb begin
      w_last_h   = (o_hcount == c_H_LAST);
      w_last_v   = (o_vcount == c_V_LAST);
      w_next_h   = w_last_h ? '0 : o_hcount + 1'b1;
      w_next_v   = o_vcount;
      if (w_last_h) begin
         w_next_v = w_last_v ? '0 : o_vcount + 1'b1;
      end
      w_next_h_x = {1'b0, w_next_h};
      w_next_v_x = {1'b0, w_next_v};
      w_hs_act   = (w_next_h_x >= c_HS_START) && (w_next_h_x < c_HS_END);
      w_vs_act   = (w_next_v_x >= c_VS_START) && (w_next_v_x < c_VS_END);
   end

   // Raster registers: all outputs update together on the pixel tick
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         o_hcount      <= c_H_LAST;
         o_vcount      <= c_V_LAST;
         o_hsync       <= ~HSYNC_POL;
         o_vsync       <= ~VSYNC_POL;
         o_video_on    <= 1'b0;
         o_line_start  <= 1'b0;
         o_frame_start <= 1'b0;
         o_frame_count <= '0;
      end else if (w_pix_tick) begin
         o_hcount      <= w_next_h;
         o_vcount      <= w_next_v;
         o_hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
         o_vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
         o_video_on    <= (w_next_h_x < c_H_VIS) && (w_next_v_x < c_V_VIS);
         o_line_start  <= (w_next_h == '0);
         o_frame_start <= (w_next_h == '0) && (w_next_v == '0);
         if (w_last_h && w_last_v) begin
            o_frame_count <= o_frame_count + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Randomised-enable bench for vga_timing_gen in a small mode,
//            checked every cycle against an arithmetic raster model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   localparam int   HV = 10, HFP = 2, HSP = 3, HBP = 4;
   localparam int   VV = 6,  VFP = 1, VSP = 2, VBP = 3;
   localparam logic HPOL = 1'b1;
   localparam logic VPOL = 1'b0;
   localparam int   DIV = 3;
   localparam int   CW  = 5;
   localparam int   FW  = 2;
   localparam int   HT  = HV + HFP + HSP + HBP;
   localparam int   VT  = VV + VFP + VSP + VBP;
   localparam int   FRAME_PIX = HT * VT;

   logic          clk = 1'b0;
   logic          i_resetn;
   logic          i_enable;
   logic          o_pix_tick;
   logic [CW-1:0] o_hcount;
   logic [CW-1:0] o_vcount;
   logic          o_hsync;
   logic          o_vsync;
   logic          o_video_on;
   logic          o_line_start;
   logic          o_frame_start;
   logic [FW-1:0] o_frame_count;

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP),
      .V_VISIBLE(VV), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP),
      .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .CLK_DIV(DIV), .COUNT_W(CW), .FRAME_W(FW)
   ) dut (
      .i_clk(clk), .i_resetn(i_resetn), .i_enable(i_enable),
      .o_pix_tick(o_pix_tick), .o_hcount(o_hcount), .o_vcount(o_vcount),
      .o_hsync(o_hsync), .o_vsync(o_vsync), .o_video_on(o_video_on),
      .o_line_start(o_line_start), .o_frame_start(o_frame_start),
      .o_frame_count(o_frame_count)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     errors = 0;
   longint n_ticks;      // pixel ticks since reset release (model)
   longint n_en;         // enabled cycles since reset release (model)
   longint cyc = 0;
   logic   prev_fs, prev_ls;
   longint last_fs_cyc;
   bit     fs_valid, ls_valid, stall_seen;
   int     line_ticks;
   int     fs_idx;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected outputs derived from the tick count with plain arithmetic
   task automatic check_outputs();
      longint pos;
      int h, v, fc;
      logic hs, vs, vid, ls, fs;
      if (n_ticks == 0) begin
         h = HT - 1; v = VT - 1; hs = ~HPOL; vs = ~VPOL;
         vid = 1'b0; ls = 1'b0; fs = 1'b0; fc = 0;
      end else begin
         pos = (n_ticks - 1) % FRAME_PIX;
         h   = int'(pos % HT);
         v   = int'(pos / HT);
         hs  = (h >= HV + HFP && h < HV + HFP + HSP) ? HPOL : ~HPOL;
         vs  = (v >= VV + VFP && v < VV + VFP + VSP) ? VPOL : ~VPOL;
         vid = (h < HV) && (v < VV);
         ls  = (h == 0);
         fs  = (h == 0) && (v == 0);
         fc  = int'(((n_ticks - 1) / FRAME_PIX + 1) % (1 << FW));
      end
      check("hcount", o_hcount, h);
      check("vcount", o_vcount, v);
      check("hsync", o_hsync, hs);
      check("vsync", o_vsync, vs);
      check("video_on", o_video_on, vid);
      check("line_start", o_line_start, ls);
      check("frame_start", o_frame_start, fs);
      check("frame_count", o_frame_count, fc);
   endtask

   task automatic restart_tracking();
      n_ticks = 0; n_en = 0;
      prev_fs = 1'b0; prev_ls = 1'b0;
      fs_valid = 1'b0; ls_valid = 1'b0; stall_seen = 1'b0;
      line_ticks = 0; fs_idx = 0; last_fs_cyc = 0;
   endtask

   // One clock: called at a negedge, returns at the following negedge
   task automatic step(input logic en);
      logic exp_tick;
      i_enable = en;
      #1;
      exp_tick = en && ((n_en % DIV) == DIV - 1);
      check("pix_tick", o_pix_tick, exp_tick);
      check_outputs();
      if (!en) stall_seen = 1'b1;
      if (o_line_start && !prev_ls) begin
         if (ls_valid) check("line_ticks", line_ticks, HT);
         ls_valid = 1'b1;
         line_ticks = 0;
      end
      line_ticks += int'(o_pix_tick);
      if (o_frame_start && !prev_fs) begin
         if (fs_valid && !stall_seen) check("frame_cycles", cyc - last_fs_cyc, FRAME_PIX * DIV);
         check("frame_seq", o_frame_count, (fs_idx + 1) % (1 << FW));
         fs_idx++;
         fs_valid = 1'b1;
         stall_seen = 1'b0;
         last_fs_cyc = cyc;
      end
      prev_ls = o_line_start;
      prev_fs = o_frame_start;
      @(posedge clk);
      if (exp_tick) n_ticks++;
      if (en) n_en++;
      cyc++;
      @(negedge clk);
   endtask

   task automatic hold_reset_checks(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         i_enable = ($urandom_range(0, 1) != 0);
         #1;
         check("rst_tick", o_pix_tick, 1'b0);
         check_outputs();
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      bit found;
      i_resetn = 1'b0;
      i_enable = 1'b0;
      restart_tracking();
      @(negedge clk);
      hold_reset_checks(3);

      // Release with enable high: first tick lands on (0,0), frame 1
      i_resetn = 1'b1;
      for (int i = 0; i < DIV; i++) step(1'b1);
      check("first_h", o_hcount, 0);
      check("first_v", o_vcount, 0);
      check("first_fs", o_frame_start, 1);
      check("first_fc", o_frame_count, 1);

      // Five-plus frames at full rate: frame length and counter wrap
      for (int i = 0; i < 5 * FRAME_PIX * DIV + 10; i++) step(1'b1);

      // Stall for 37 cycles on the last visible pixel of a line
      found = 1'b0;
      for (int i = 0; i < HT * DIV * 2 && !found; i++) begin
         if (o_hcount == CW'(HV - 1)) found = 1'b1;
         else step(1'b1);
      end
      check("stall_reach", found, 1);
      for (int i = 0; i < 37; i++) step(1'b0);
      for (int i = 0; i < 3 * HT * DIV; i++) step(1'b1);

      // Randomised enable
      for (int i = 0; i < 15000; i++) step($urandom_range(0, 9) != 0);

      // Asynchronous reset asserted mid-cycle, mid-frame
      #2;
      i_resetn = 1'b0;
      restart_tracking();
      #1;
      check("async_rst_h", o_hcount, HT - 1);
      check_outputs();
      @(negedge clk);
      hold_reset_checks(2);
      i_resetn = 1'b1;
      for (int i = 0; i < 3000; i++) step($urandom_range(0, 4) != 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
